// File: rtl/lsu_byte_sequencer.sv
// Load/store sequencer: serialises one LB/LH/LW/LBU/LHU/SB/SH/SW request into
// 1-4 little-endian byte accesses on a byte-wide RAM and returns a completion.
module lsu_byte_sequencer #(
   parameter int unsigned ADDR_W = 14
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              req_valid_i,
   output logic              req_ready_o,
   input  logic              req_we_i,
   input  logic [1:0]        req_size_i,
   input  logic              req_unsigned_i,
   input  logic [31:0]       req_addr_i,
   input  logic [31:0]       req_wdata_i,
   output logic              rsp_valid_o,
   output logic [31:0]       rsp_rdata_o,
   output logic              rsp_misaligned_o,
   output logic [ADDR_W-1:0] ram_addr_o,
   output logic              ram_wren_o,
   output logic [7:0]        ram_wdata_o,
   input  logic [7:0]        ram_rdata_i
);

   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

   state_t            r_state;
   logic              r_we;
   logic [1:0]        r_size;
   logic              r_uns;
   logic [ADDR_W-1:0] r_addr;
   logic [31:0]       r_wdata;
   logic [1:0]        r_cnt;
   logic [31:0]       r_result;
   logic              r_rsp_valid;
   logic [31:0]       r_rsp_rdata;
   logic              r_rsp_mis;
   logic [ADDR_W-1:0] r_ram_addr;
   logic              r_ram_wren;
   logic [7:0]        r_ram_wdata;

   logic              w_req_mis;
   logic              w_last;
   logic [1:0]        w_cnt_nxt;
   logic [31:0]       w_result_nxt;
   logic [31:0]       w_ext;
   logic              w_unused_addr;

   // Upper address bits are deliberately dropped: the RAM aliases.
   assign w_unused_addr = ^req_addr_i[31:ADDR_W];

   assign w_req_mis = (req_size_i == 2'b11)
                    | ((req_size_i == 2'b01) & req_addr_i[0])
                    | ((req_size_i == 2'b10) & (req_addr_i[1:0] != 2'b00));

   // Last byte index N-1 is 0/1/3 for byte/half/word.
   assign w_last    = (r_cnt == {r_size[1], |r_size});
   assign w_cnt_nxt = r_cnt + 2'd1;

   always_comb begin
      w_result_nxt = r_result;
      w_result_nxt[{r_cnt, 3'b000} +: 8] = ram_rdata_i;
   end

   always_comb begin
      unique case (r_size)
         2'b00:   w_ext = {{24{~r_uns & w_result_nxt[7]}},  w_result_nxt[7:0]};
         2'b01:   w_ext = {{16{~r_uns & w_result_nxt[15]}}, w_result_nxt[15:0]};
         default: w_ext = w_result_nxt;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state     <= S_IDLE;
         r_we        <= 1'b0;
         r_size      <= '0;
         r_uns       <= 1'b0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_cnt       <= '0;
         r_result    <= '0;
         r_rsp_valid <= 1'b0;
         r_rsp_rdata <= '0;
         r_rsp_mis   <= 1'b0;
         r_ram_addr  <= '0;
         r_ram_wren  <= 1'b0;
         r_ram_wdata <= '0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (req_valid_i) begin
                  r_we    <= req_we_i;
                  r_size  <= req_size_i;
                  r_uns   <= req_unsigned_i;
                  r_addr  <= req_addr_i[ADDR_W-1:0];
                  r_wdata <= req_wdata_i;
                  if (w_req_mis) begin
                     r_state     <= S_RESP;
                     r_rsp_valid <= 1'b1;
                     r_rsp_mis   <= 1'b1;
                     r_rsp_rdata <= '0;
                  end else begin
                     // RAM outputs are registered, so byte 0 is presented from the accept edge.
                     r_state     <= S_ACCESS;
                     r_cnt       <= '0;
                     r_result    <= '0;
                     r_ram_addr  <= req_addr_i[ADDR_W-1:0];
                     r_ram_wren  <= req_we_i;
                     r_ram_wdata <= req_wdata_i[7:0];
                  end
               end
            end
            S_ACCESS: begin
               if (!r_we) begin
                  r_result <= w_result_nxt;
               end
               if (w_last) begin
                  r_state     <= S_RESP;
                  r_ram_wren  <= 1'b0;
                  r_rsp_valid <= 1'b1;
                  r_rsp_mis   <= 1'b0;
                  r_rsp_rdata <= r_we ? '0 : w_ext;
               end else begin
                  r_cnt       <= w_cnt_nxt;
                  r_ram_addr  <= r_addr + ADDR_W'(w_cnt_nxt);
                  r_ram_wdata <= r_wdata[{w_cnt_nxt, 3'b000} +: 8];
               end
            end
            S_RESP: begin
               r_state     <= S_IDLE;
               r_rsp_valid <= 1'b0;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign req_ready_o      = (r_state == S_IDLE);
   assign rsp_valid_o      = r_rsp_valid;
   assign rsp_rdata_o      = r_rsp_rdata;
   assign rsp_misaligned_o = r_rsp_mis;
   assign ram_addr_o       = r_ram_addr;
   assign ram_wren_o       = r_ram_wren;
   assign ram_wdata_o      = r_ram_wdata;

endmodule

// File: tb/tb_lsu_byte_sequencer.sv
// Directed bench for lsu_byte_sequencer with a behavioural 16K byte RAM.
module tb_lsu_byte_sequencer;

   localparam int unsigned ADDR_W = 14;

   logic              clk_i = 1'b0;
   logic              rst_ni = 1'b0;
   logic              req_valid_i = 1'b0;
   logic              req_ready_o;
   logic              req_we_i = 1'b0;
   logic [1:0]        req_size_i = '0;
   logic              req_unsigned_i = 1'b0;
   logic [31:0]       req_addr_i = '0;
   logic [31:0]       req_wdata_i = '0;
   logic              rsp_valid_o;
   logic [31:0]       rsp_rdata_o;
   logic              rsp_misaligned_o;
   logic [ADDR_W-1:0] ram_addr_o;
   logic              ram_wren_o;
   logic [7:0]        ram_wdata_o;
   logic [7:0]        ram_rdata_i;

   logic [7:0]        mem [0:(1<<ADDR_W)-1];
   int                cyc = 0;
   int                wr_addr_q[$];
   int                wr_data_q[$];
   int                wr_cyc_q[$];
   int                n_checks = 0;
   int                n_errors = 0;

   lsu_byte_sequencer #(.ADDR_W(ADDR_W)) u_dut (
      .clk_i            (clk_i),
      .rst_ni           (rst_ni),
      .req_valid_i      (req_valid_i),
      .req_ready_o      (req_ready_o),
      .req_we_i         (req_we_i),
      .req_size_i       (req_size_i),
      .req_unsigned_i   (req_unsigned_i),
      .req_addr_i       (req_addr_i),
      .req_wdata_i      (req_wdata_i),
      .rsp_valid_o      (rsp_valid_o),
      .rsp_rdata_o      (rsp_rdata_o),
      .rsp_misaligned_o (rsp_misaligned_o),
      .ram_addr_o       (ram_addr_o),
      .ram_wren_o       (ram_wren_o),
      .ram_wdata_o      (ram_wdata_o),
      .ram_rdata_i      (ram_rdata_i)
   );

   always #5 clk_i = ~clk_i;

   assign ram_rdata_i = mem[ram_addr_o];

   always @(posedge clk_i) begin
      cyc = cyc + 1;
      if (ram_wren_o) begin
         mem[ram_addr_o] = ram_wdata_o;
         wr_addr_q.push_back(int'(ram_addr_o));
         wr_data_q.push_back(int'(ram_wdata_o));
         wr_cyc_q.push_back(cyc);
      end
   end

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
      end
   endtask

   task automatic run_req(input string tag, input logic we, input logic [1:0] size,
                          input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rdata, input logic exp_mis, input int exp_lat);
      int lat;
      int rdy_hi;
      @(negedge clk_i);
      chk({tag, " ready_idle"}, 32'(req_ready_o), 32'd1);
      req_we_i       = we;
      req_size_i     = size;
      req_unsigned_i = uns;
      req_addr_i     = addr;
      req_wdata_i    = wdata;
      req_valid_i    = 1'b1;
      @(posedge clk_i);
      @(negedge clk_i);
      req_valid_i = 1'b0;
      lat    = 0;
      rdy_hi = 0;
      for (int c = 1; c <= 10; c++) begin
         if (c > 1) @(negedge clk_i);
         if (req_ready_o) rdy_hi++;
         if (rsp_valid_o) begin
            lat = c;
            break;
         end
      end
      chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
      chk({tag, " rdata"}, rsp_rdata_o, exp_rdata);
      chk({tag, " misaligned"}, 32'(rsp_misaligned_o), 32'(exp_mis));
      chk({tag, " ready_busy"}, 32'(rdy_hi), 32'd0);
      @(negedge clk_i);
      chk({tag, " rsp_pulse"}, 32'(rsp_valid_o), 32'd0);
   endtask

   initial begin
      int n_wr;
      for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 8'h00;
      mem[14'h200] = 8'hAA;
      mem[14'h201] = 8'hBB;
      mem[14'h202] = 8'hCC;
      mem[14'h203] = 8'hDD;

      #12;
      chk("rst ready", 32'(req_ready_o), 32'd1);
      chk("rst rsp_valid", 32'(rsp_valid_o), 32'd0);
      chk("rst rdata", rsp_rdata_o, 32'd0);
      chk("rst mis", 32'(rsp_misaligned_o), 32'd0);
      chk("rst wren", 32'(ram_wren_o), 32'd0);
      chk("rst addr", 32'(ram_addr_o), 32'd0);
      chk("rst wdata", 32'(ram_wdata_o), 32'd0);
      @(negedge clk_i);
      rst_ni = 1'b1;

      // 1: SW 0xDEADBEEF @0x100
      wr_addr_q.delete(); wr_data_q.delete(); wr_cyc_q.delete();
      run_req("sw", 1'b1, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF, 32'h0, 1'b0, 5);
      chk("sw nwrites", 32'(wr_addr_q.size()), 32'd4);
      if (wr_addr_q.size() == 4) begin
         for (int i = 0; i < 4; i++) begin
            chk($sformatf("sw wr%0d addr", i), 32'(wr_addr_q[i]), 32'h100 + 32'(i));
            chk($sformatf("sw wr%0d cyc", i), 32'(wr_cyc_q[i] - wr_cyc_q[0]), 32'(i));
         end
         chk("sw wr0 data", 32'(wr_data_q[0]), 32'hEF);
         chk("sw wr1 data", 32'(wr_data_q[1]), 32'hBE);
         chk("sw wr2 data", 32'(wr_data_q[2]), 32'hAD);
         chk("sw wr3 data", 32'(wr_data_q[3]), 32'hDE);
      end

      // 2-3: loads back
      run_req("lw",  1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 1'b0, 5);
      run_req("lb",  1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 32'hFFFFFFDE, 1'b0, 2);
      run_req("lbu", 1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 32'h000000DE, 1'b0, 2);
      run_req("lh",  1'b0, 2'b01, 1'b0, 32'h102, 32'h0, 32'hFFFFDEAD, 1'b0, 3);
      run_req("lhu", 1'b0, 2'b01, 1'b1, 32'h102, 32'h0, 32'h0000DEAD, 1'b0, 3);
      run_req("lbp", 1'b0, 2'b00, 1'b0, 32'h101, 32'h0, 32'hFFFFFFBE, 1'b0, 2);

      // 4: misaligned requests make no RAM access
      n_wr = wr_addr_q.size();
      run_req("mis lw",  1'b0, 2'b10, 1'b0, 32'h102, 32'h0,        32'h0, 1'b1, 1);
      run_req("mis sh",  1'b1, 2'b01, 1'b0, 32'h101, 32'h12345678, 32'h0, 1'b1, 1);
      run_req("mis s11", 1'b1, 2'b11, 1'b0, 32'h100, 32'h12345678, 32'h0, 1'b1, 1);
      chk("mis nowrite", 32'(wr_addr_q.size()), 32'(n_wr));
      chk("mis mem", {mem[14'h103], mem[14'h102], mem[14'h101], mem[14'h100]}, 32'hDEADBEEF);

      // 5: back-to-back with req_valid_i held; SB aliases to address 0
      begin
         int rsp1, rsp2, rdy_c;
         logic [31:0] d1, d2;
         rsp1 = 0; rsp2 = 0; rdy_c = 0; d1 = '1; d2 = '1;
         @(negedge clk_i);
         req_we_i = 1'b1; req_size_i = 2'b00; req_unsigned_i = 1'b0;
         req_addr_i = 32'h4000; req_wdata_i = 32'hFFFFFF5A; req_valid_i = 1'b1;
         @(posedge clk_i);
         #1;
         req_we_i = 1'b0; req_unsigned_i = 1'b1; req_addr_i = 32'h0; req_wdata_i = '0;
         for (int c = 1; c <= 12; c++) begin
            @(negedge clk_i);
            if (req_ready_o && rdy_c == 0) begin
               rdy_c = c;
               @(posedge clk_i);
               #1 req_valid_i = 1'b0;
               @(negedge clk_i);
               c++;
            end
            if (rsp_valid_o) begin
               if (rsp1 == 0) begin rsp1 = c; d1 = rsp_rdata_o; end
               else begin rsp2 = c; d2 = rsp_rdata_o; break; end
            end
         end
         req_valid_i = 1'b0;
         chk("b2b rsp1 cyc", 32'(rsp1), 32'd2);
         chk("b2b rsp1 data", d1, 32'h0);
         chk("b2b accept cyc", 32'(rdy_c), 32'd3);
         chk("b2b rsp2 cyc", 32'(rsp2), 32'd5);
         chk("b2b rsp2 data", d2, 32'h0000005A);
         chk("b2b alias mem", 32'(mem[0]), 32'h5A);
      end

      // 6: reset after two bytes of SW 0x11223344 @0x200
      @(negedge clk_i);
      @(negedge clk_i);
      n_wr = wr_addr_q.size();
      req_we_i = 1'b1; req_size_i = 2'b10; req_unsigned_i = 1'b0;
      req_addr_i = 32'h200; req_wdata_i = 32'h11223344; req_valid_i = 1'b1;
      @(posedge clk_i);
      @(negedge clk_i);
      req_valid_i = 1'b0;
      @(negedge clk_i);
      @(negedge clk_i);
      rst_ni = 1'b0;
      #1;
      chk("arst wren", 32'(ram_wren_o), 32'd0);
      chk("arst addr", 32'(ram_addr_o), 32'd0);
      chk("arst wdata", 32'(ram_wdata_o), 32'd0);
      chk("arst ready", 32'(req_ready_o), 32'd1);
      chk("arst rsp_valid", 32'(rsp_valid_o), 32'd0);
      chk("arst nwrites", 32'(wr_addr_q.size() - n_wr), 32'd2);
      begin
         int rsp_seen;
         rsp_seen = 0;
         for (int c = 0; c < 3; c++) begin
            @(negedge clk_i);
            if (rsp_valid_o) rsp_seen++;
         end
         rst_ni = 1'b1;
         for (int c = 0; c < 3; c++) begin
            @(negedge clk_i);
            if (rsp_valid_o) rsp_seen++;
         end
         chk("arst no_rsp", 32'(rsp_seen), 32'd0);
      end
      run_req("lw after rst", 1'b0, 2'b10, 1'b0, 32'h200, 32'h0, 32'hDDCC3344, 1'b0, 5);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got stuck expected completion");
      $fatal(1, "timeout");
   end

endmodule
